// File: rtl/filt_pkg.sv
// Shared types and sizing helpers for the multi-channel moving-average scheduler.
package filt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_DW  = 8;
  localparam int DEF_NCH = 2;

  // Channel tag width; a single-bit tag is kept even for NCH=2 or fewer.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avg4_core.sv
// Combinational 4-tap average: sign-extended sum of four samples, floored divide by 4.
module avg4_core
  import filt_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] h1,
  input  logic signed [DW-1:0] h2,
  input  logic signed [DW-1:0] h3,
  output logic signed [DW-1:0] avg
);

  logic signed [DW+1:0] sum;

  // Two guard bits hold the worst-case sum; >>>2 brings it back into DW bits.
  always_comb begin
    sum = {{2{x[DW-1]}}, x} + {{2{h1[DW-1]}}, h1}
        + {{2{h2[DW-1]}}, h2} + {{2{h3[DW-1]}}, h3};
    avg = DW'(sum >>> 2);
  end

endmodule

// File: rtl/filter_scheduler.sv
// Round-robin scheduler sharing one 4-tap averager across NCH channels, with
// per-channel history, warm-up counts and a single held, tagged result.
module filter_scheduler
  import filt_pkg::*;
#(
  parameter  int NCH = DEF_NCH,
  parameter  int DW  = DEF_DW,
  localparam int CW  = ch_width(NCH)
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_ch,
  output logic              out_warm,
  output state_t            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; in_ready is a one-hot grant valid only in IDLE, and out_valid
  // holds with stable data until out_ready is seen.

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [DW-1:0]   x_q, x_d;
  logic [DW-1:0]   hist_q [NCH][3];
  logic [DW-1:0]   hist_d [NCH][3];
  logic [1:0]      cnt_q  [NCH];
  logic [1:0]      cnt_d  [NCH];
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]   out_ch_q, out_ch_d;
  logic            out_warm_q, out_warm_d;
  logic [CW-1:0]   sel;
  logic            sel_found;
  logic [DW-1:0]   avg;

  avg4_core #(.DW(DW)) u_avg (
    .x   (x_q),
    .h1  (hist_q[grant_q][0]),
    .h2  (hist_q[grant_q][1]),
    .h3  (hist_q[grant_q][2]),
    .avg (avg)
  );

  // First requester at or after rr_q, wrapping.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!sel_found && in_valid[(int'(rr_q) + i) % NCH]) begin
        sel_found = 1'b1;
        sel       = CW'((int'(rr_q) + i) % NCH);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (!reset && state_q == IDLE && enable && sel_found) in_ready[sel] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    x_d        = x_q;
    hist_d     = hist_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    out_warm_d = out_warm_q;
    case (state_q)
      IDLE: begin
        if (enable && sel_found) begin
          grant_d = sel;
          x_d     = in_data[sel*DW +: DW];
          state_d = CALC;
        end
      end
      CALC: begin
        out_data_d = avg;
        out_ch_d   = grant_q;
        out_warm_d = (cnt_q[grant_q] == 2'd3);
        hist_d[grant_q][2] = hist_q[grant_q][1];
        hist_d[grant_q][1] = hist_q[grant_q][0];
        hist_d[grant_q][0] = x_q;
        if (cnt_q[grant_q] != 2'd3) cnt_d[grant_q] = cnt_q[grant_q] + 2'd1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          rr_d    = (grant_q == CW'(NCH - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides any history update in the same cycle.
    if (flush) begin
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < 3; t++) hist_d[c][t] = '0;
        cnt_d[c] = 2'd0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      x_q        <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_warm_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < 3; t++) hist_q[c][t] <= '0;
        cnt_q[c] <= 2'd0;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      x_q        <= x_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      out_warm_q <= out_warm_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_warm  = out_warm_q;
  assign dbg_state = state_q;

endmodule

// File: doc/filter_scheduler.md
# filter_scheduler

Round-robin scheduler that shares one 4-tap moving-average datapath between NCH sample channels. It holds the per-channel delay history, arbitrates among channels with pending samples, and sequences each accepted sample through the averager. It presents one tagged, flow-controlled result at a time to the downstream consumer. It sits between the per-channel sample sources and the post-filter logic, replacing one free-running averager per channel.

## Interface
- NCH, 2, number of requesting channels (2..8)
- DW, 8, sample and result width, two's-complement
- CLK100MHZ  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  high: new grants allowed; low: in-flight sample still completes
- flush  in  1  synchronous pulse; zeroes all histories and warm-up counts
- in_valid  in  NCH  per-channel sample pending
- in_data  in  NCH*DW  channel k sample in bits [k*DW +: DW]
- in_ready  out  NCH  one-hot accept strobe
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  DW  signed average
- out_ch  out  CW  channel tag of out_data; CW = max(1, clog2(NCH))
- out_warm  out  1  high when the average spans 4 real samples of that channel

## Operation
- States are IDLE, CALC and HOLD.
- IDLE:
  - When enable=1 and any in_valid is set, grant the first requesting channel at or after rr_ptr, wrapping modulo NCH.
  - in_ready is combinational: one-hot for the granted channel, zero otherwise.
  - On the accept edge, latch the sample and channel, then go to CALC.
  - If no channel is requesting, or enable=0, in_ready=0 and stay in IDLE.
- CALC:
  - sum = x + h1 + h2 + h3 for the granted channel, sign-extended to DW+2 bits.
  - out_data = sum >>> 2, arithmetic shift, which floors toward minus infinity. The result always fits in DW bits, so there is no saturation logic.
  - Shift that channel's history: h3<=h2, h2<=h1, h1<=x.
  - out_warm = (count==3) before the increment. Then increment count, saturating at 3.
  - Register out_ch, then go to HOLD.
- HOLD:
  - out_valid=1.
  - out_data, out_ch and out_warm are held stable until out_valid&out_ready.
  - On that handshake: go to IDLE, and set rr_ptr to granted+1 mod NCH.
- Other channels' histories never change on a grant.
- flush:
  - Clears every history to 0 and every count to 0 on the next edge.
  - If flush coincides with a CALC history update, flush wins: the history ends at zero.
  - The in-flight out_data is still computed from the pre-flush history, and its handshake still completes.
- enable falling in CALC or HOLD does not abort; the sequence finishes normally.
- in_valid dropping while not granted is legal; nothing is latched.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, all histories and counts 0.
  - out_valid=0, out_data=0, out_ch=0, out_warm=0.
  - in_ready=0 for as long as reset is high.
- Reset asserted mid-CALC or mid-HOLD discards the sample. No output handshake follows.
- Latency: accept on cycle N (in_valid&in_ready); out_valid is high from cycle N+2.
- If out_ready is held high, the handshake occurs at N+2 and the next accept occurs earliest at N+3. Peak throughput is one sample per 3 cycles.
- out_valid drops on the cycle after the handshake.
- The in_ready pulse lasts exactly one cycle per accepted sample.

## Structure
- Package filt_pkg:
  - state enum (IDLE, CALC, HOLD)
  - default DW and NCH
  - a ch_width(NCH) function returning CW
- Sub-module avg4_core: combinational, 4 signed DW inputs to a DW-bit result, implementing the sign-extend, add and >>>2 rule above.
- History storage is NCH x 3 x DW registers plus NCH 2-bit counts, kept in filter_scheduler. No RAM is used.

## Test plan
- Single channel warm-up:
  - Stimulus: ch0 sends 4, 8, 12, 16 with out_ready=1.
  - Response: out_data = 1, 3, 6, 10; out_warm = 0, 0, 0, 1; out_ch=0. Each out_valid rises 2 cycles after its accept.
- Extremes:
  - Stimulus: ch1 sends four samples of 127, then four of -128.
  - Response: the 4th result is 127 and the 8th result is -128.
  - Stimulus: history all zero, then a single sample of -1.
  - Response: out_data = -1.
- Round-robin fairness:
  - Stimulus: ch0 and ch1 hold in_valid continuously.
  - Response: grants alternate 0,1,0,1 starting at ch0 after reset. Each channel's history stays independent: ch0 all 4s and ch1 all 8s give results 4 and 8 once warm.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in HOLD.
  - Response: out_data, out_ch and out_warm are stable; in_ready=0 throughout. One handshake follows when out_ready rises.
- Flush collision:
  - Stimulus: assert flush in the CALC cycle of a warm ch0 sample.
  - Response: the result uses the old history. The next ch0 result has out_warm=0 and averages against zeros.
- Async reset:
  - Stimulus: assert reset mid-HOLD.
  - Response: out_valid falls immediately (no clock edge needed). After release, rr_ptr=0 and the first result has out_warm=0.
